receiver: RTL and testbench

RECEIVER -- requirements
Module: receiver

---
 rtl/receiver.sv | 136 +++++++++++++
 tb/tb_receiver.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/receiver.sv
// UART receiver: two-flop synchronized RxD, mid-bit sampling, 8 data bits LSB first.
// Define RX_PARITY_EN to expect an even-parity bit between the data bits and the stop bit.
module receiver #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RxD,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       framing_error,
  output logic       parity_error,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

`ifdef RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t          r_state;
  state_t          w_next;
  logic            r_sync1;
  logic            r_sync2;
  logic            r_prev;
  logic [1:0]      r_live;
  logic            r_armed;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            w_fall;
  logic            w_half;
  logic            w_tick;
  logic            w_par_bad;

  // r_armed stays low after reset until a genuine (post-reset) high has reached rx_s,
  // so a line held low across reset cannot masquerade as a start edge.
  assign w_fall = r_armed & r_prev & ~r_sync2;
  assign w_half = (r_cnt == HALF);
  assign w_tick = (r_cnt == FULL);

`ifdef RX_PARITY_EN
  logic r_par_bad;
  logic r_perr;
  assign w_par_bad    = r_par_bad;
  assign parity_error = r_perr;
`else
  assign w_par_bad    = 1'b0;
  assign parity_error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_fall) w_next = S_START;
      S_START: if (w_half) w_next = r_sync2 ? S_IDLE : S_DATA;
`ifdef RX_PARITY_EN
      S_DATA:   if (w_tick && r_bit == 3'd7) w_next = S_PARITY;
      S_PARITY: if (w_tick) w_next = S_STOP;
`else
      S_DATA:   if (w_tick && r_bit == 3'd7) w_next = S_STOP;
`endif
      S_STOP:  if (w_tick) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1       <= 1'b1;
      r_sync2       <= 1'b1;
      r_prev        <= 1'b1;
      r_live        <= 2'b00;
      r_armed       <= 1'b0;
      r_cnt         <= '0;
      r_bit         <= 3'd0;
      r_shift       <= 8'd0;
      data          <= 8'd0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
`ifdef RX_PARITY_EN
      r_par_bad     <= 1'b0;
      r_perr        <= 1'b0;
`endif
    end else begin
      r_sync1 <= RxD;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_live  <= {r_live[0], 1'b1};
      if (r_live[1] && r_sync2) r_armed <= 1'b1;

      if (w_next != r_state || r_state == S_IDLE || w_tick) r_cnt <= '0;
      else                                                   r_cnt <= r_cnt + 1'b1;

      data_valid    <= 1'b0;
      framing_error <= 1'b0;
`ifdef RX_PARITY_EN
      r_perr        <= 1'b0;
      if (r_state == S_IDLE) r_par_bad <= 1'b0;
      if (r_state == S_PARITY && w_tick) r_par_bad <= r_sync2 ^ (^r_shift);
`endif
      if (r_state == S_IDLE) r_bit <= 3'd0;

      if (r_state == S_DATA && w_tick) begin
        r_shift <= {r_sync2, r_shift[7:1]};
        r_bit   <= r_bit + 1'b1;
      end

      if (r_state == S_STOP && w_tick) begin
        framing_error <= ~r_sync2;
`ifdef RX_PARITY_EN
        r_perr        <= r_par_bad;
`endif
        if (r_sync2 && !w_par_bad) begin
          data       <= r_shift;
          data_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_receiver.sv
// Directed plus randomized bench for receiver at 16 clocks per bit; builds with or without RX_PARITY_EN.
module tb_receiver;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       RxD = 1'b1;
  logic [7:0] data;
  logic       data_valid;
  logic       framing_error;
  logic       parity_error;
  logic       busy;

  receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .RxD(RxD), .data(data), .data_valid(data_valid),
    .framing_error(framing_error), .parity_error(parity_error), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Observed events, accumulated by the monitor.
  byte unsigned got_q[$];
  int   n_fe = 0, n_pe = 0, n_dbl = 0, n_ovl = 0;
  logic p_dv = 1'b0, p_fe = 1'b0, p_pe = 1'b0;
  logic mon_en = 1'b0;

  // Reference model state: what a correct receiver must have reported so far.
  byte unsigned exp_q[$];
  logic [7:0] exp_data = 8'd0;
  int   exp_fe = 0, exp_pe = 0;
  int   vidx = 0;
  logic g_flip = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (data_valid) got_q.push_back(data);
      if (framing_error) n_fe <= n_fe + 1;
      if (parity_error) n_pe <= n_pe + 1;
      if ((data_valid && p_dv) || (framing_error && p_fe) || (parity_error && p_pe)) n_dbl <= n_dbl + 1;
      if (data_valid && (framing_error || parity_error)) n_ovl <= n_ovl + 1;
    end
    p_dv <= data_valid;
    p_fe <= framing_error;
    p_pe <= parity_error;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    RxD = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    RxD = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // rst_bit >= 0 pulses reset for one cycle in the middle of that data bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_b, input int rst_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == rst_bit) begin
        RxD = b[i];
        repeat (8) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (7) @(posedge clk);
        #1;
      end else begin
        drive_bit(b[i]);
      end
    end
`ifdef RX_PARITY_EN
    drive_bit((^b) ^ g_flip);
`endif
    drive_bit(stop_b);
  endtask

  // A frame is delivered only if its stop bit is 1 and its parity (when present) is even.
  task automatic model(input logic [7:0] b, input logic stop_b, input logic par_flip);
    logic ok_par;
    ok_par = !par_flip;
    if (stop_b && ok_par) begin
      exp_q.push_back(b);
      exp_data = b;
    end
    if (!stop_b) exp_fe++;
    if (!ok_par) exp_pe++;
  endtask

  task automatic verify(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = vidx; i < got_q.size() && i < exp_q.size(); i++)
      check({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
    vidx = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    check({tag, "_ferr"}, 32'(n_fe), 32'(exp_fe));
    check({tag, "_perr"}, 32'(n_pe), 32'(exp_pe));
    check({tag, "_width"}, 32'(n_dbl), 32'd0);
    check({tag, "_overlap"}, 32'(n_ovl), 32'd0);
    check({tag, "_data"}, 32'(data), 32'(exp_data));
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] rb;
    logic       rs;
    int         gap;

    repeat (3) @(posedge clk);
    #1;
    check("rst_data", 32'(data), 32'd0);
    check("rst_dv", 32'(data_valid), 32'd0);
    check("rst_fe", 32'(framing_error), 32'd0);
    check("rst_pe", 32'(parity_error), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    mon_en = 1'b1;
    idle(5);

    g_flip = 1'b0;
    send_frame(8'hA5, 1'b1, -1);
    model(8'hA5, 1'b1, 1'b0);
    idle(4);
    verify("a5");

    send_frame(8'h3C, 1'b0, -1);
    model(8'h3C, 1'b0, 1'b0);
    idle(20);
    verify("frame_err");

    RxD = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("glitch_busy_hi", 32'(busy), 32'd1);
    idle(12);
    verify("glitch");

    send_frame(8'h00, 1'b1, -1);
    model(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, -1);
    model(8'hFF, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1, -1);
    model(8'h55, 1'b1, 1'b0);
    idle(8);
    verify("b2b");

    send_frame(8'h81, 1'b1, 3);
    exp_data = 8'd0;
    idle(20);
    send_frame(8'h7E, 1'b1, -1);
    model(8'h7E, 1'b1, 1'b0);
    idle(8);
    verify("reset_mid");

`ifdef RX_PARITY_EN
    g_flip = 1'b1;
    send_frame(8'h07, 1'b1, -1);
    model(8'h07, 1'b1, g_flip);
    idle(8);
    g_flip = 1'b0;
    send_frame(8'h07, 1'b1, -1);
    model(8'h07, 1'b1, g_flip);
    idle(8);
    verify("parity");
`endif

    for (int k = 0; k < 12; k++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
`ifdef RX_PARITY_EN
      g_flip = ($urandom_range(0, 3) == 0);
`endif
      send_frame(rb, rs, -1);
      model(rb, rs, g_flip);
      gap = rs ? int'($urandom_range(0, 3)) : int'($urandom_range(2, 6));
      idle(gap);
    end
    idle(20);
    verify("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
